// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALUOp, funct, ALU codes, mul/div ops, FSM states.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ALUOP_ADD  = 3'b000,
    ALUOP_SUB  = 3'b001,
    ALUOP_RFMT = 3'b010,
    ALUOP_AND  = 3'b011,
    ALUOP_OR   = 3'b100,
    ALUOP_SLT  = 3'b101,
    ALUOP_XOR  = 3'b110,
    ALUOP_RSVD = 3'b111
  } aluop_e;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_SRA   = 6'd3;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SUBU  = 6'd35;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_XOR   = 6'd38;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLTU  = 6'd43;

  localparam logic [3:0] CODE_AND  = 4'b0000;
  localparam logic [3:0] CODE_OR   = 4'b0001;
  localparam logic [3:0] CODE_ADD  = 4'b0010;
  localparam logic [3:0] CODE_SLL  = 4'b0011;
  localparam logic [3:0] CODE_SRL  = 4'b0100;
  localparam logic [3:0] CODE_SRA  = 4'b0101;
  localparam logic [3:0] CODE_SUB  = 4'b0110;
  localparam logic [3:0] CODE_SLT  = 4'b0111;
  localparam logic [3:0] CODE_SLTU = 4'b1000;
  localparam logic [3:0] CODE_NOR  = 4'b1100;
  localparam logic [3:0] CODE_XOR  = 4'b1101;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Decode request/response bundle between the ID stage (master) and the ALU control sequencer (slave).
interface alu_ctrl_seq_if #(
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [ALUOP_W-1:0] aluop;
  logic [5:0]         funct;
  logic               flush;
  logic               out_valid;
  logic [CTRL_W-1:0]  alucontrol;
  logic               sign;
  logic               jr;
  logic               md_start;
  logic [1:0]         md_op;
  logic               md_done;
  logic               stall;
  logic               illegal;

  modport master (
    output in_valid, aluop, funct, flush,
    input  in_ready, out_valid, alucontrol, sign, jr, md_start, md_op, md_done, stall, illegal
  );

  modport slave (
    input  in_valid, aluop, funct, flush,
    output in_ready, out_valid, alucontrol, sign, jr, md_start, md_op, md_done, stall, illegal
  );
endinterface

// File: rtl/alu_funct_decode.sv
// Combinational ALUOp/funct decoder: ALU code, sign/jr flags, mul/div detection and undefined-encoding flag.
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] code_o,
  output logic       sign_o,
  output logic       jr_o,
  output logic       is_md_o,
  output logic [1:0] md_op_o,
  output logic       undef_o
);

  always_comb begin
    code_o  = CODE_ADD;
    sign_o  = 1'b1;
    jr_o    = 1'b0;
    is_md_o = 1'b0;
    md_op_o = MD_MULT;
    undef_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: code_o = CODE_ADD;
      ALUOP_SUB: code_o = CODE_SUB;
      ALUOP_AND: begin code_o = CODE_AND; sign_o = 1'b0; end
      ALUOP_OR:  begin code_o = CODE_OR;  sign_o = 1'b0; end
      ALUOP_SLT: code_o = CODE_SLT;
      ALUOP_XOR: begin code_o = CODE_XOR; sign_o = 1'b0; end
      ALUOP_RFMT: begin
        // mul/div and jr ride through the ALU as ADD; the sequencer handles the rest
        case (funct_i)
          FN_ADD, FN_ADDU: code_o = CODE_ADD;
          FN_SUB, FN_SUBU: code_o = CODE_SUB;
          FN_AND:          code_o = CODE_AND;
          FN_OR:           code_o = CODE_OR;
          FN_XOR:          code_o = CODE_XOR;
          FN_NOR:          code_o = CODE_NOR;
          FN_SLT:          code_o = CODE_SLT;
          FN_SLTU:         code_o = CODE_SLTU;
          FN_SLL:          code_o = CODE_SLL;
          FN_SRL:          code_o = CODE_SRL;
          FN_SRA:          code_o = CODE_SRA;
          FN_JR:           jr_o   = 1'b1;
          FN_MULT:  begin is_md_o = 1'b1; md_op_o = MD_MULT;  end
          FN_MULTU: begin is_md_o = 1'b1; md_op_o = MD_MULTU; end
          FN_DIV:   begin is_md_o = 1'b1; md_op_o = MD_DIV;   end
          FN_DIVU:  begin is_md_o = 1'b1; md_op_o = MD_DIVU;  end
          default:         undef_o = 1'b1;
        endcase
      end
      default: undef_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder for the ID/EX boundary with a fixed-latency mul/div sequencer.
// Define ALUCTRL_ILLEGAL_TRAP_EN to report undefined aluop/funct encodings on 'illegal'.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4,
  parameter int MD_LAT  = 32,
  parameter int CNT_W   = 8
) (
  input logic           clk,
  input logic           reset_n,
  alu_ctrl_seq_if.slave bus
);

`ifdef ALUCTRL_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  if (ALUOP_W != 3) begin : gBadAluopW
    $error("alu_ctrl_seq: ALUOP_W must be 3");
  end
  if (CTRL_W < 4) begin : gBadCtrlW
    $error("alu_ctrl_seq: CTRL_W must be at least 4");
  end
  if (MD_LAT < 2 || MD_LAT > 255) begin : gBadMdLat
    $error("alu_ctrl_seq: MD_LAT must be within 2..255");
  end
  if (CNT_W < 1 || CNT_W > 30 || (1 << CNT_W) <= MD_LAT) begin : gBadCntW
    $error("alu_ctrl_seq: 2**CNT_W must exceed MD_LAT");
  end

  localparam logic [CNT_W-1:0] MdLoad = CNT_W'(MD_LAT - 1);

  logic [3:0] decCode;
  logic       decSign, decJr, decIsMd, decUndef;
  logic [1:0] decMdOp;

  alu_funct_decode uDecode (
    .aluop_i (bus.aluop),
    .funct_i (bus.funct),
    .code_o  (decCode),
    .sign_o  (decSign),
    .jr_o    (decJr),
    .is_md_o (decIsMd),
    .md_op_o (decMdOp),
    .undef_o (decUndef)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               outValid_q, outValid_d;
  logic [CTRL_W-1:0]  aluCtrl_q, aluCtrl_d;
  logic               sign_q, sign_d, jr_q, jr_d;
  logic               mdStart_q, mdStart_d;
  logic [1:0]         mdOp_q, mdOp_d;
  logic               illegal_q, illegal_d;
  logic               cntZero, inReady, accept, mdLaunch, mdDone;

  // The last busy cycle already counts as idle, so a new request can follow md_done directly
  assign cntZero  = (cnt_q == '0);
  assign inReady  = (state_q == IDLE) || cntZero;
  assign accept   = bus.in_valid && inReady && !bus.flush;
  assign mdLaunch = accept && decIsMd;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    outValid_d = accept;
    aluCtrl_d  = aluCtrl_q;
    sign_d     = sign_q;
    jr_d       = jr_q;
    mdStart_d  = 1'b0;
    mdOp_d     = mdOp_q;
    illegal_d  = illegal_q;
    mdDone     = 1'b0;
    if (bus.flush) illegal_d = 1'b0;
    if (accept) begin
      aluCtrl_d = CTRL_W'(decCode);
      sign_d    = decSign;
      jr_d      = decJr;
      illegal_d = TrapEn && decUndef;
    end
    case (state_q)
      IDLE: ;
      MD_RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cntZero) begin
          mdDone  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
    if (mdLaunch) begin
      state_d   = MD_RUN;
      cnt_d     = MdLoad;
      mdStart_d = 1'b1;
      mdOp_d    = decMdOp;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      outValid_q <= 1'b0;
      aluCtrl_q  <= '0;
      sign_q     <= 1'b0;
      jr_q       <= 1'b0;
      mdStart_q  <= 1'b0;
      mdOp_q     <= 2'b00;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      outValid_q <= outValid_d;
      aluCtrl_q  <= aluCtrl_d;
      sign_q     <= sign_d;
      jr_q       <= jr_d;
      mdStart_q  <= mdStart_d;
      mdOp_q     <= mdOp_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.out_valid  = outValid_q;
  assign bus.alucontrol = aluCtrl_q;
  assign bus.sign       = sign_q;
  assign bus.jr         = jr_q;
  assign bus.md_start   = mdStart_q;
  assign bus.md_op      = mdOp_q;
  assign bus.md_done    = mdDone;
  assign bus.stall      = (state_q == MD_RUN);
  assign bus.illegal    = illegal_q;

endmodule
